// File: rtl/alu_defs.sv
// ALU control codes shared by the ALU and every block that feeds it.
package alu_defs;

  localparam int ALUCTRL_W = 4;

  localparam logic [ALUCTRL_W-1:0] ALUCTRL_AND = 4'b0000;
  localparam logic [ALUCTRL_W-1:0] ALUCTRL_OR  = 4'b0001;
  localparam logic [ALUCTRL_W-1:0] ALUCTRL_ADD = 4'b0010;
  localparam logic [ALUCTRL_W-1:0] ALUCTRL_SUB = 4'b0110;
  localparam logic [ALUCTRL_W-1:0] ALUCTRL_SLT = 4'b0111;
  localparam logic [ALUCTRL_W-1:0] ALUCTRL_NOR = 4'b1100;

  function automatic logic is_supported(input logic [ALUCTRL_W-1:0] ctrl);
    logic ok;
    case (ctrl)
      ALUCTRL_AND, ALUCTRL_OR, ALUCTRL_ADD,
      ALUCTRL_SUB, ALUCTRL_SLT, ALUCTRL_NOR: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_chk.sv
// Protocol properties for alu_share_arbiter, observed from its ports only.
module alu_share_arbiter_chk #(
  parameter int NREQ = 2
) (
  input logic            clk,
  input logic            rst_n,
  input logic [NREQ-1:0] req_ready,
  input logic [NREQ-1:0] rsp_valid
);

  a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
  a_rdy_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_no_accept_while_resp : assert property (@(posedge clk) disable iff (!rst_n)
                                            (rsp_valid != '0) |-> (req_ready == '0));

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  localparam logic [PW:0] NREQ_E = (PW+1)'(NREQ);

  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [PW:0]       off_s;
  logic [PW:0]       sum_s;
  logic [PW:0]       wrap_s;

  // Rotate so that bit 0 of rot_s is the requester at ptr.
  assign dbl_s = {req, req} >> ptr;
  assign rot_s = dbl_s[NREQ-1:0];

  // Priority search over the rotated vector, then map back to an absolute index.
  always_comb begin
    valid  = 1'b0;
    off_s  = '0;
    grant  = '0;
    for (int k = 0; k < NREQ; k++) begin
      off_s = (!valid && rot_s[k]) ? (PW+1)'(k) : off_s;
      valid = valid | rot_s[k];
    end
    sum_s  = {1'b0, ptr} + off_s;
    wrap_s = (sum_s >= NREQ_E) ? (sum_s - NREQ_E) : sum_s;
    idx    = wrap_s[PW-1:0];
    for (int j = 0; j < NREQ; j++) begin
      grant[j] = valid && (idx == PW'(j));
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ requesters,
// one op in flight, registered ALU inputs and registered responses.
module alu_share_arbiter
  import alu_defs::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [ALUCTRL_W*NREQ-1:0] req_ctrl,
  input  logic [WIDTH*NREQ-1:0]     req_a,
  input  logic [WIDTH*NREQ-1:0]     req_b,
  output logic [ALUCTRL_W-1:0]      alu_ctrl,
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  input  logic [WIDTH-1:0]          alu_result,
  input  logic                      alu_zero,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [WIDTH-1:0]          rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_r;
  logic [PW-1:0]          ptr_r;
  logic [PW-1:0]          id_r;
  logic [NREQ-1:0]        grant_s;
  logic [PW-1:0]          win_s;
  logic                   found_s;
  logic [ALUCTRL_W-1:0]   win_ctrl_s;
  logic [WIDTH-1:0]       win_a_s;
  logic [WIDTH-1:0]       win_b_s;
  logic [NREQ-1:0]        id_onehot_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (win_s),
    .valid (found_s)
  );

  // Accept only while idle; the grant itself is combinational so the op is taken this cycle.
  assign req_ready   = (state_r == ST_IDLE) ? grant_s : '0;
  assign win_ctrl_s  = req_ctrl[32'(win_s)*ALUCTRL_W +: ALUCTRL_W];
  assign win_a_s     = req_a[32'(win_s)*WIDTH +: WIDTH];
  assign win_b_s     = req_b[32'(win_s)*WIDTH +: WIDTH];
  assign id_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << id_r;

  // Control FSM with registered ALU operands and response holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      id_r       <= '0;
      alu_ctrl   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            alu_ctrl <= win_ctrl_s;
            alu_a    <= win_a_s;
            alu_b    <= win_b_s;
            id_r     <= win_s;
            ptr_r    <= (win_s == LAST_IDX) ? '0 : (win_s + PW'(1'b1));
            state_r  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU holds stale output on unknown codes, so those get a fixed error response.
          if (is_supported(alu_ctrl)) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b1;
          end
          rsp_valid <= id_onehot_s;
          state_r   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[id_r]) begin
            rsp_valid <= '0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
module tb_alu_share_arbiter;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(2), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  alu_share_arbiter_chk #(.NREQ(2)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid)
  );

  // Shared ALU model; unknown codes drive garbage that must never reach a response.
  always_comb begin
    case (alu_ctrl)
      ALUCTRL_AND: alu_result = alu_a & alu_b;
      ALUCTRL_OR:  alu_result = alu_a | alu_b;
      ALUCTRL_ADD: alu_result = alu_a + alu_b;
      ALUCTRL_SUB: alu_result = alu_a - alu_b;
      ALUCTRL_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALUCTRL_NOR: alu_result = ~(alu_a | alu_b);
      default:     alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid[r]       = 1'b1;
    req_ctrl[r*4 +: 4] = c;
    req_a[r*32 +: 32]  = a;
    req_b[r*32 +: 32]  = b;
  endtask

  // Called on a negedge with the request already up; returns on the EXEC-cycle negedge.
  task automatic grant_op(input int r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (req_ready[r]) ok = 1'b1;
      else @(negedge clk);
    end
    check_eq("grant", 64'(ok), 64'd1);
    @(negedge clk);
    req_valid[r] = 1'b0;
    check_eq("ready_exec", 64'(req_ready), 64'd0);
    check_eq("alu_ctrl", 64'(alu_ctrl), 64'(c));
    check_eq("alu_a", 64'(alu_a), 64'(a));
    check_eq("alu_b", 64'(alu_b), 64'(b));
  endtask

  // Waits for the response from the EXEC negedge, checks it, then consumes it.
  task automatic finish_op(input int r, input logic [31:0] res, input logic z, input logic e);
    int n = 0;
    logic [1:0] oh;
    oh = 2'b01 << r;
    while (rsp_valid == 2'b00 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", 64'(n), 64'd1);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(oh));
    check_eq("rsp_result", 64'(rsp_result), 64'(res));
    check_eq("rsp_zero", 64'(rsp_zero), 64'(z));
    check_eq("rsp_err", 64'(rsp_err), 64'(e));
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
    check_eq("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_ctrl  = 8'h00;
    req_a     = 64'd0;
    req_b     = 64'd0;
    rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check_eq("rst_alu_a", 64'(alu_a), 64'd0);
    check_eq("rst_alu_b", 64'(alu_b), 64'd0);
    check_eq("rst_rsp_result", 64'(rsp_result), 64'd0);
    check_eq("rst_rsp_flags", 64'({rsp_zero, rsp_err}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_no_req", 64'(req_ready), 64'd0);

    // Single op: ready in the request cycle, response two cycles later.
    issue(0, ALUCTRL_ADD, 32'd5, 32'd7);
    #1 check_eq("single_ready", 64'(req_ready), 64'b01);
    grant_op(0, ALUCTRL_ADD, 32'd5, 32'd7);
    finish_op(0, 32'd12, 1'b0, 1'b0);

    // req1 alone; afterwards ptr has wrapped back to 0.
    issue(1, ALUCTRL_SUB, 32'd9, 32'd9);
    grant_op(1, ALUCTRL_SUB, 32'd9, 32'd9);
    finish_op(1, 32'd0, 1'b1, 1'b0);

    // Contention with ptr=0: req0 first, req1 blocked until RESP exits.
    issue(0, ALUCTRL_SLT, 32'd3, 32'd8);
    issue(1, ALUCTRL_NOR, 32'd0, 32'd0);
    #1 check_eq("cont_first", 64'(req_ready), 64'b01);
    grant_op(0, ALUCTRL_SLT, 32'd3, 32'd8);
    finish_op(0, 32'd1, 1'b0, 1'b0);
    #1 check_eq("cont_second", 64'(req_ready), 64'b10);
    grant_op(1, ALUCTRL_NOR, 32'd0, 32'd0);
    finish_op(1, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Unsupported code: fixed error response regardless of the ALU output.
    issue(1, 4'b1111, 32'd4, 32'd4);
    grant_op(1, 4'b1111, 32'd4, 32'd4);
    finish_op(1, 32'd0, 1'b1, 1'b1);

    // Backpressure; rsp_ready of the other requester must be ignored.
    issue(0, ALUCTRL_AND, 32'h0000F0F0, 32'h0000FF00);
    issue(1, ALUCTRL_OR, 32'd1, 32'd2);
    #1 check_eq("rr_wrap", 64'(req_ready), 64'b01);
    grant_op(0, ALUCTRL_AND, 32'h0000F0F0, 32'h0000FF00);
    @(negedge clk);
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 64'(rsp_valid), 64'b01);
      check_eq("bp_result", 64'(rsp_result), 64'h0000F000);
      check_eq("bp_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    check_eq("bp_release", 64'(rsp_valid), 64'd0);
    #1 check_eq("bp_idle_next", 64'(req_ready), 64'b10);
    grant_op(1, ALUCTRL_OR, 32'd1, 32'd2);
    finish_op(1, 32'd3, 1'b0, 1'b0);

    // Reset during EXEC aborts the op asynchronously.
    issue(0, ALUCTRL_ADD, 32'd1, 32'd2);
    grant_op(0, ALUCTRL_ADD, 32'd1, 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_alu", 64'({alu_ctrl, alu_a, alu_b}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
    end
    issue(1, ALUCTRL_ADD, 32'hFFFFFFFF, 32'd1);
    grant_op(1, ALUCTRL_ADD, 32'hFFFFFFFF, 32'd1);
    finish_op(1, 32'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
